// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the RAM program loader.
package loader_pkg;

  localparam int unsigned RAM_DEPTH = 16;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned DATA_W    = 8;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  // VERIFY is only reachable when LOADER_VERIFY_EN is defined.
  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    WAIT_GNT,
    DRIVE,
    WRITE,
    VERIFY,
    NEXT,
    DONE
  } loader_state_t;

endpackage

// File: rtl/ram_program_loader.sv
// Loads a 16-byte program into RAM over a shared tri-state bus.
// Optional read-back verify of each byte: define LOADER_VERIFY_EN.
module ram_program_loader
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] address,
  output logic              read_from_bus,
  output logic              write_to_bus,
  inout  wire  [DATA_W-1:0] bus,
  output logic              busy,
  output logic              done,
  output logic              error
);

  loader_state_t     state, state_next;
  logic [DATA_W-1:0] hold_q;
  logic              drive_en;

  // The loader only drives the bus while it owns a byte in DRIVE/WRITE.
  assign bus = drive_en ? hold_q : 'z;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (start)     state_next = WAIT_BYTE;
      WAIT_BYTE: if (in_valid)  state_next = WAIT_GNT;
      WAIT_GNT:  if (bus_grant) state_next = DRIVE;
      DRIVE:     state_next = bus_grant ? WRITE : WAIT_GNT;
`ifdef LOADER_VERIFY_EN
      WRITE:     state_next = VERIFY;
      VERIFY:    state_next = NEXT;
`else
      WRITE:     state_next = NEXT;
      VERIFY:    state_next = IDLE;
`endif
      NEXT:      state_next = (address == LAST_ADDR) ? DONE : WAIT_BYTE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Outputs decoded from the current state only.
  always_comb begin
    in_ready      = 1'b0;
    read_from_bus = 1'b0;
    write_to_bus  = 1'b0;
    drive_en      = 1'b0;
    done          = 1'b0;
    busy          = (state != IDLE);
    unique case (state)
      WAIT_BYTE: in_ready = 1'b1;
      DRIVE:     drive_en = 1'b1;
      WRITE: begin
        drive_en      = 1'b1;
        read_from_bus = 1'b1;
      end
`ifdef LOADER_VERIFY_EN
      VERIFY:    write_to_bus = 1'b1;
`endif
      DONE:      done = 1'b1;
      default:   ;
    endcase
  end

  // Address counter and captured program byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address <= '0;
      hold_q  <= '0;
    end else begin
      if (state == IDLE && start)
        address <= '0;
      else if (state == NEXT && address != LAST_ADDR)
        address <= address + ADDR_W'(1);
      if (state == WAIT_BYTE && in_valid)
        hold_q <= in_data;
    end
  end

`ifdef LOADER_VERIFY_EN
  // Sticky mismatch flag; cleared only by a new start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      error <= 1'b0;
    else if (state == IDLE && start)
      error <= 1'b0;
    else if (state == VERIFY && bus != hold_q)
      error <= 1'b1;
  end
`else
  logic unused_bus;
  assign unused_bus = ^bus;
  assign error      = 1'b0;
`endif

endmodule

// File: doc/ram_program_loader.md
RAM_PROGRAM_LOADER -- requirements
Module: ram_program_loader

Interface
REQ-001 SHALL provide port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL provide port rst_n, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-003 SHALL provide port start, input, 1 bit: begin a 16-byte load; sampled only in IDLE.
REQ-004 SHALL provide port in_valid, input, 1 bit: in_data holds a program byte.
REQ-005 SHALL provide port in_data, input, 8 bits: program byte from the upstream source.
REQ-006 SHALL provide port in_ready, output, 1 bit: loader accepts in_data this cycle.
REQ-007 SHALL provide port bus_grant, input, 1 bit: CPU controller has released the shared 8-bit bus.
REQ-008 SHALL provide port address, output, 4 bits: RAM address being loaded.
REQ-009 SHALL provide port read_from_bus, output, 1 bit: RAM latches the bus on this clock edge.
REQ-010 SHALL provide port write_to_bus, output, 1 bit: RAM drives the bus (verify read-back only).
REQ-011 SHALL provide port bus, inout, 8 bits: shared tri-state bus; 'z unless the loader is driving.
REQ-012 SHALL provide port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL provide port done, output, 1 bit: one-cycle pulse after address 15 is committed.
REQ-014 SHALL provide port error, output, 1 bit: sticky verify mismatch flag.

Function
REQ-015 SHALL implement states IDLE, WAIT_BYTE, WAIT_GNT, DRIVE, WRITE, VERIFY (macro only), NEXT, DONE.
REQ-016 SHALL go from IDLE to WAIT_BYTE when start=1, clearing address to 0 and error to 0; start in any other state is ignored.
REQ-017 SHALL assert in_ready only in WAIT_BYTE; an in_valid&in_ready cycle captures in_data into a hold register and moves to WAIT_GNT.
REQ-018 SHALL stay in WAIT_GNT until bus_grant=1, then go to DRIVE.
REQ-019 SHALL drive bus with the held byte in DRIVE and WRITE only, with read_from_bus=0 in DRIVE as a setup cycle.
REQ-020 SHALL return from DRIVE to WAIT_GNT, releasing the bus and keeping the held byte, if bus_grant=0 in DRIVE.
REQ-021 SHALL assert read_from_bus for exactly one cycle in WRITE, regardless of bus_grant; the write is committed at the end of WRITE.
REQ-022 SHALL never assert read_from_bus and write_to_bus together, and never drive bus while write_to_bus=1.
REQ-023 SHALL in NEXT release the bus; at address 15 go to DONE, otherwise increment address and go to WAIT_BYTE.
REQ-024 SHALL pulse done for the single DONE cycle, then return to IDLE with address held at 15.
REQ-025 SHALL not wrap address during a load; the 4-bit increment from 15 is never taken.
REQ-026 SHALL give a minimum per-byte latency, from acceptance to the next in_ready, of 4 cycles (5 with the macro), assuming grant is already present.

Reset
REQ-027 SHALL on rst_n=0 immediately enter IDLE, release the bus, and set address=0, read_from_bus=0, write_to_bus=0, in_ready=0, busy=0, done=0, error=0, hold register=0.
REQ-028 SHALL on reset mid-load abandon the load; bytes already written stay in RAM and no done is issued.

Configuration
REQ-029 SHALL with macro LOADER_VERIFY_EN defined route WRITE to VERIFY, which releases the bus, asserts write_to_bus for one cycle, and compares bus with the held byte at the closing edge. A mismatch sets error, and the load continues.
REQ-030 SHALL without LOADER_VERIFY_EN route WRITE directly to NEXT, omit VERIFY, and tie error to 0.

Structure
REQ-031 SHALL take RAM_DEPTH=16, ADDR_W=4, DATA_W=8 and the state enum from shared package loader_pkg.
REQ-032 SHALL be a single module; the tri-state bus driver is a continuous assign on a drive-enable, with no sub-module.

Verification
REQ-033 Full load: start, 16 bytes 0x00..0x0F, grant held high -> RAM[i]=i for all i, one done pulse, busy falls the cycle after done.
REQ-034 Backpressure: in_valid low for 5 cycles before byte 3 -> in_ready stays high, address stays 2, no read_from_bus pulse.
REQ-035 Grant loss: bus_grant dropped during DRIVE of byte 0xA5 at address 4 -> bus goes 'z, state is WAIT_GNT; on re-grant RAM[4]=0xA5 with exactly one read_from_bus pulse.
REQ-036 Reset mid-load: rst_n low after address 7 -> bus 'z in the same cycle, all outputs at reset values, no done; a new start reloads from address 0.
REQ-037 Verify (LOADER_VERIFY_EN): RAM model corrupts address 9 to 0x00 when 0x3C is written -> error=1 from the VERIFY cycle on, load completes, done pulses.
REQ-038 Start while busy: start pulsed at address 5 -> ignored, load finishes normally at address 15.
